// File: rtl/adaptive_filter_diff_mac_sched.sv
// Time-multiplexed 10-tap antisymmetric FIR differentiator: one pre-subtractor,
// one multiplier and one accumulator walk the 5 coefficient pairs per accepted sample.
module adaptive_filter_diff_mac_sched #(
   parameter int                    IN_WL    = 14,
   parameter int                    COEFF_WL = 9,
   parameter int                    OUT_WL   = 20,
   parameter logic [5*COEFF_WL-1:0] COEFF    = {9'h04C, 9'h038, 9'h1CD, 9'h019, 9'h1FE}
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [IN_WL-1:0]  in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [OUT_WL-1:0] out_data_o,
   output logic              out_sat_o
);

   localparam int NTAPS   = 10;
   localparam int NPAIR   = NTAPS / 2;
   localparam int DIFF_WL = IN_WL + 1;
   localparam int PROD_WL = DIFF_WL + COEFF_WL;
   localparam int ACC_WL  = PROD_WL + $clog2(NPAIR);
   localparam int HI_WL   = ACC_WL - OUT_WL + 1;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t                   state_q, state_d;
   logic [2:0]               k_q;
   logic                     rdy_en_q;
   logic signed [IN_WL-1:0]  d_q [NTAPS];
   logic signed [ACC_WL-1:0] acc_q;
   logic                     out_valid_q, out_sat_q;
   logic [OUT_WL-1:0]        out_data_q;

   logic                     accept, mac_en, last_mac;
   logic [3:0]               idx_a, idx_b;
   logic signed [IN_WL-1:0]  tap_a, tap_b;
   logic signed [COEFF_WL-1:0] coef_tab [NPAIR];
   logic signed [COEFF_WL-1:0] coef;
   logic signed [DIFF_WL-1:0]  diff;
   logic signed [PROD_WL-1:0]  prod;
   logic signed [ACC_WL-1:0]   acc_sum, sh;
   logic [HI_WL-1:0]           hi;
   logic                       ovf;
   logic [OUT_WL-1:0]          res;

   for (genvar g = 0; g < NPAIR; g++) begin : g_coef
      assign coef_tab[g] = COEFF[g*COEFF_WL +: COEFF_WL];
   end

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM: next state; flush overrides every transition
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (accept)      state_d = S_MAC;
            S_MAC:   if (last_mac)    state_d = S_OUT;
            S_OUT:   if (out_ready_i) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
         endcase
      end
   end

   // FSM: outputs / datapath enables
   always_comb begin
      in_ready_o = (state_q == S_IDLE) && rdy_en_q;
      accept     = in_valid_i && in_ready_o && !flush_i;
      mac_en     = (state_q == S_MAC);
      last_mac   = mac_en && (k_q == 3'(NPAIR-1));
   end

   // Pair k pulls the newest-side tap k and its mirror 9-k.
   always_comb begin
      idx_a   = {1'b0, k_q};
      idx_b   = 4'(NTAPS-1) - idx_a;
      tap_a   = d_q[idx_a];
      tap_b   = d_q[idx_b];
      coef    = coef_tab[k_q];
      diff    = {tap_a[IN_WL-1], tap_a} - {tap_b[IN_WL-1], tap_b};
      prod    = PROD_WL'(diff) * PROD_WL'(coef);
      acc_sum = acc_q + ACC_WL'(prod);
      sh      = acc_sum >>> 1;
      hi      = sh[ACC_WL-1:OUT_WL-1];
      ovf     = !((&hi) || !(|hi));
      if (ovf) res = sh[ACC_WL-1] ? {1'b1, {(OUT_WL-1){1'b0}}} : {1'b0, {(OUT_WL-1){1'b1}}};
      else     res = sh[OUT_WL-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) rdy_en_q <= 1'b0;
      else          rdy_en_q <= 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) begin
         for (int i = 0; i < NTAPS; i++) d_q[i] <= '0;
         acc_q       <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         if (accept) begin
            d_q[0] <= in_data_i;
            for (int i = 1; i < NTAPS; i++) d_q[i] <= d_q[i-1];
            acc_q <= '0;
            k_q   <= '0;
         end
         if (mac_en) begin
            acc_q <= acc_sum;
            k_q   <= k_q + 3'd1;
         end
         // Result is registered on the final tap so it holds unchanged under backpressure.
         if (last_mac) begin
            out_valid_q <= 1'b1;
            out_data_q  <= res;
            out_sat_q   <= ovf;
         end else if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_sat_o   = out_sat_q;

endmodule
